// File: rtl/ctr_pkg.sv
// Shared constants for the cascaded BCD/hex up/down counter.
package ctr_pkg;
    localparam int DIGIT_W = 4;

    localparam logic MODE_HEX = 1'b0;
    localparam logic MODE_BCD = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'h9;
    localparam logic [DIGIT_W-1:0] HEX_MAX = 4'hF;
endpackage

// File: rtl/ctr_digit.sv
// One 4-bit counter digit: loadable, steps up/down within 0..MAX of the current mode.
module ctr_digit
    import ctr_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               step_i,
    input  logic               updown_i,
    input  logic               mode_i,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] load_dig_i,
    output logic [DIGIT_W-1:0] dig_o,
    output logic               at_max_o,
    output logic               at_zero_o
);
    logic [DIGIT_W-1:0] dig_q, dig_d, max_v, step_v, load_v;
    logic               oor;

    assign max_v = (mode_i == MODE_BCD) ? BCD_MAX : HEX_MAX;
    // A digit above 9 in BCD mode (left over from hex) behaves as terminal.
    assign oor       = dig_q > max_v;
    assign at_max_o  = dig_q >= max_v;
    assign at_zero_o = dig_q == '0;
    assign dig_o     = dig_q;

    assign load_v = ((mode_i == MODE_BCD) && (load_dig_i > BCD_MAX)) ? BCD_MAX : load_dig_i;

    always_comb begin
        step_v = dig_q;
        if (updown_i == DIR_UP)
            step_v = at_max_o ? '0 : dig_q + 4'd1;
        else
            step_v = (at_zero_o || oor) ? max_v : dig_q - 4'd1;
    end

    always_comb begin
        dig_d = dig_q;
        if (load_i)
            dig_d = load_v;
        else if (step_i)
            dig_d = step_v;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) dig_q <= '0;
        else       dig_q <= dig_d;
    end
endmodule

// File: rtl/bcd_hex_ud_counter_n.sv
// DIGITS cascaded BCD/hex digits forming one loadable up/down counter with wrap or saturate.
module bcd_hex_ud_counter_n
    import ctr_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    updown,
    input  logic                    mode,
    input  logic                    load,
    input  logic [4*DIGITS-1:0]     load_value,
    output logic [4*DIGITS-1:0]     count_out,
    output logic                    done,
    output logic                    wrap
);
    logic [DIGITS-1:0] at_max, at_zero, step;
    logic [DIGITS:0]   chain;
    logic              tc, adv, wrap_d, wrap_q;

    assign tc   = (updown == DIR_UP) ? &at_max : &at_zero;
    assign done = tc;
    assign adv  = enable && !load && !((SATURATE != 0) && tc);

    // chain[i] is high when every digit below i sits at its terminal for the direction.
    assign chain[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        assign chain[i+1] = chain[i] && ((updown == DIR_UP) ? at_max[i] : at_zero[i]);
        assign step[i]    = adv && chain[i];

        ctr_digit u_dig (
            .clk        (clk),
            .reset      (reset),
            .step_i     (step[i]),
            .updown_i   (updown),
            .mode_i     (mode),
            .load_i     (load),
            .load_dig_i (load_value[DIGIT_W*i +: DIGIT_W]),
            .dig_o      (count_out[DIGIT_W*i +: DIGIT_W]),
            .at_max_o   (at_max[i]),
            .at_zero_o  (at_zero[i])
        );
    end

    assign wrap_d = enable && !load && tc && (SATURATE == 0);
    assign wrap   = wrap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wrap_q <= 1'b0;
        else       wrap_q <= wrap_d;
    end
endmodule
